// File: rtl/dds_sweep_ctrl_pkg.sv
// dds_pkg: shared controller state type and default DDS widths
package dds_pkg;
  localparam int DDS_TW = 10;
  localparam int DDS_PW = 15;
  localparam int DDS_OW = 24;
  typedef enum logic [1:0] {IDLE, LOAD, ARM, SWEEP} dds_ctrl_state_t;
endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: valid/ready waveform table load stream
interface dds_sweep_ctrl_if import dds_pkg::*; #(parameter int OW = DDS_OW);
  logic          wl_valid;
  logic          wl_ready;
  logic [OW-1:0] wl_data;
  logic          wl_last;
  modport master (output wl_valid, wl_data, wl_last, input wl_ready);
  modport slave  (input wl_valid, wl_data, wl_last, output wl_ready);
endinterface

// File: rtl/dds_sweep_ctrl_loader.sv
// dds_wfm_loader: turns the load stream into sequential DDS table writes and flags framing errors
module dds_wfm_loader import dds_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int OW    = DDS_OW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          abort_i,
  dds_sweep_ctrl_if.slave wl,
  output logic          wea_o,
  output logic [AW-1:0] waddr_o,
  output logic [OW-1:0] din_o,
  output logic          err_o,
  output logic          last_beat_o
);
  logic          ready_q, wea_q, err_q, accept, at_end;
  logic [AW-1:0] addr_q, waddr_q;
  logic [OW-1:0] din_q;
  assign accept      = wl.wl_valid & ready_q;
  assign at_end      = addr_q == AW'(DEPTH - 1);
  assign last_beat_o = accept & at_end;
  assign wl.wl_ready = ready_q;
  assign wea_o       = wea_q;
  assign waddr_o     = waddr_q;
  assign din_o       = din_q;
  assign err_o       = err_q;
  // ready follows the FSM's next state; each accepted beat is written one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      wea_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      ready_q <= en_i;
      wea_q   <= accept;
      if (clr_i) addr_q <= '0;
      else if (accept) addr_q <= at_end ? '0 : addr_q + 1'b1;
      if (accept) begin
        waddr_q <= addr_q;
        din_q   <= wl.wl_data;
      end
      if (clr_i) err_q <= 1'b0;
      else if (abort_i || (accept && (wl.wl_last != at_end))) err_q <= 1'b1;
    end
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sequences DDS table loads and linear frequency sweeps
module dds_sweep_ctrl import dds_pkg::*; #(
  parameter int TW    = DDS_TW,
  parameter int PW    = DDS_PW,
  parameter int DEPTH = 1024,
  parameter int OW    = DDS_OW,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_req,
  input  logic                     start,
  input  logic                     abort,
  input  logic [TW-1:0]            cfg_start_tw,
  input  logic [TW-1:0]            cfg_stop_tw,
  input  logic [TW-1:0]            cfg_step_tw,
  input  logic [CW-1:0]            cfg_dwell,
  input  logic [PW-1:0]            cfg_start_phase,
  input  logic                     cfg_repeat,
  dds_sweep_ctrl_if.slave          wl,
  output logic                     dds_ce,
  output logic                     dds_rst,
  output logic [TW-1:0]            dds_tuning_word,
  output logic [PW-1:0]            dds_start_phase,
  output logic                     dds_wfm_wea,
  output logic [$clog2(DEPTH)-1:0] dds_wfm_waddr,
  output logic [OW-1:0]            dds_wfm_din,
  output logic                     busy,
  output logic                     done,
  output logic                     load_err
);
  dds_ctrl_state_t state_q, state_d;
  logic            ce_q, arm_q, busy_q, done_q, rep_q, last_beat, step_end, fits;
  logic [TW-1:0]   tw_q, start_q, stop_q, step_q;
  logic [PW-1:0]   phase_q;
  logic [CW-1:0]   dwell_q, cnt_q;
  logic [TW:0]     nxt;
  assign nxt             = {1'b0, tw_q} + {1'b0, step_q};
  assign fits            = !nxt[TW] && (nxt[TW-1:0] <= stop_q);
  assign step_end        = cnt_q == dwell_q;
  assign dds_ce          = ce_q;
  assign dds_rst         = arm_q;
  assign dds_tuning_word = tw_q;
  assign dds_start_phase = phase_q;
  assign busy            = busy_q;
  assign done            = done_q;
  dds_wfm_loader #(.DEPTH(DEPTH), .OW(OW)) u_loader (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q == IDLE && state_d == LOAD),
    .en_i        (state_d == LOAD),
    .abort_i     (abort && state_q == LOAD),
    .wl          (wl),
    .wea_o       (dds_wfm_wea),
    .waddr_o     (dds_wfm_waddr),
    .din_o       (dds_wfm_din),
    .err_o       (load_err),
    .last_beat_o (last_beat)
  );
  // next state: load beats start, sweep ends only without repeat when the next step leaves range
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load_req ? LOAD : start ? ARM : IDLE;
      LOAD:    state_d = last_beat ? IDLE : LOAD;
      ARM:     state_d = SWEEP;
      SWEEP:   state_d = (step_end && !fits && !rep_q) ? IDLE : SWEEP;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // state, registered outputs and sweep working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      arm_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rep_q   <= 1'b0;
      tw_q    <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      phase_q <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= state_d == SWEEP;
      arm_q   <= state_d == ARM;
      busy_q  <= state_d != IDLE;
      done_q  <= state_q == SWEEP && state_d == IDLE && !abort;
      if (state_q == IDLE && state_d == ARM) begin
        start_q <= cfg_start_tw;
        stop_q  <= cfg_stop_tw;
        step_q  <= cfg_step_tw;
        dwell_q <= cfg_dwell;
        rep_q   <= cfg_repeat;
        phase_q <= cfg_start_phase;
        tw_q    <= cfg_start_tw;
        cnt_q   <= '0;
      end else if (state_q == SWEEP) begin
        cnt_q <= step_end ? '0 : cnt_q + 1'b1;
        if (step_end) tw_q <= fits ? nxt[TW-1:0] : start_q;
      end
    end
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer for the `dds` waveform generator.
- Loads the DDS waveform table from a valid/ready stream.
- Runs programmable linear frequency sweeps (chirps) by driving the DDS tuning word, phase reset and clock enable.
- Sits between the register/config layer and one `dds` instance; all `dds_*` outputs connect directly to the same-named DDS inputs.

## Interface
- `TW`, 10: tuning word width; must equal the DDS `TW`.
- `PW`, 15: phase width; must equal the DDS `PW`.
- `DEPTH`, 1024: waveform table entries; must equal the DDS `DEPTH`.
- `OW`, 24: sample width; must equal the DDS `OW`.
- `CW`, 16: dwell counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `load_req` in 1: pulse; start a table load.
- `start` in 1: pulse; start a sweep.
- `abort` in 1: pulse; stop any operation.
- `cfg_start_tw`, `cfg_stop_tw`, `cfg_step_tw` in TW each: sweep start, stop and increment.
- `cfg_dwell` in CW: a step lasts cfg_dwell+1 cycles.
- `cfg_start_phase` in PW: initial phase.
- `cfg_repeat` in 1: restart from start_tw after the last step instead of finishing.
- `wl_valid` in 1, `wl_ready` out 1, `wl_data` in OW, `wl_last` in 1: table load stream.
- `dds_ce` out 1, `dds_rst` out 1, `dds_tuning_word` out TW, `dds_start_phase` out PW: DDS control.
- `dds_wfm_wea` out 1, `dds_wfm_waddr` out $clog2(DEPTH), `dds_wfm_din` out OW: DDS table write port.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse at sweep completion.
- `load_err` out 1: sticky wl_last mismatch flag.

## Operation
- States are IDLE, LOAD, ARM, SWEEP.
- **IDLE**
  - `load_req` → LOAD; clears `load_err` and the write address.
  - Otherwise `start` → ARM.
  - `load_req` and `start` in the same cycle: load wins and start is dropped.
  - Requests in any other state are ignored.
- **LOAD**
  - `wl_ready`=1.
  - Each accepted beat writes `wl_data` at addresses 0,1,…,DEPTH-1.
  - After beat DEPTH-1 → IDLE.
  - Mismatch (`wl_last` on any other beat, or absent on beat DEPTH-1) sets `load_err`. The beat count still governs completion; the write still happens.
- **ARM**
  - One cycle.
  - Latches all cfg_* inputs into working registers; later cfg changes have no effect until the next start.
  - `dds_rst`=1, `dds_start_phase`=cfg_start_phase, `dds_tuning_word`=cfg_start_tw.
  - → SWEEP.
- **SWEEP**
  - `dds_ce`=1 every cycle.
  - Dwell counter counts 0..dwell; at dwell it computes next = tw + step in TW+1 bits.
  - If next ≤ stop and there is no carry: tw ← next.
  - Otherwise, with repeat=1: tw ← start_tw.
  - Otherwise: pulse `done` → IDLE.
  - step=0 holds a constant tone until `abort`.
  - start_tw > stop_tw: dwells one step at start_tw, then ends or repeats.
- **abort**, any state: → IDLE next cycle.
  - `dds_ce`=0, `wl_ready`=0, no `done` pulse.
  - A partial load leaves partially written table entries and sets `load_err`.
- **rst** has the same effect as abort; it also clears `load_err`, the working registers and all outputs.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, load_err=0, wl_ready=0, dds_ce=0, dds_rst=0, dds_wfm_wea=0, dds_tuning_word=0, dds_start_phase=0, dds_wfm_waddr=0, dds_wfm_din=0.
- Load: a beat accepted in cycle n gives `dds_wfm_wea`=1 with its address/data in cycle n+1.
- `wl_ready` falls the cycle after the final beat's handshake; `busy` falls that same cycle.
- Sweep:
  - `start` at cycle n → ARM at n+1 (`dds_rst`=1).
  - First `dds_ce` at n+2 with tw=start_tw.
  - Each tw value is present on exactly dwell+1 consecutive `dds_ce` cycles.
  - On the final step, `done`=1 in the cycle after the last `dds_ce` cycle; busy=0 and dds_ce=0 in that same cycle.
- `dds_rst` is high only in ARM and is never asserted with `dds_ce`.

## Structure
- Shared package `dds_pkg`:
  - `dds_ctrl_state_t` enum (IDLE, LOAD, ARM, SWEEP).
  - Default width constants TW/PW/OW.
- Natural sub-module `dds_wfm_loader`: stream-to-table-write-port with address counter and last check, enabled by the FSM.
- The FSM, dwell counter and tw arithmetic stay in the top module.

## Test plan
- Load with DEPTH=16, 16 beats of data i*3, `wl_last` on beat 15 → writes addr 0..15 with 0,3,…,45; load_err=0; busy drops after 16 writes.
- `wl_last` on beat 7 of 16 → all 16 written; load_err=1; the next `load_req` clears it.
- start=100, stop=130, step=10, dwell=2, repeat=0 → dds_rst pulse, then tw 100,100,100,110×3,120×3,130×3; then done pulse; 12 ce cycles total.
- Overflow: start=1000, stop=1023, step=20, dwell=0 → tw 1000, 1020, then done; no wrap to 16.
- repeat=1, start=5, stop=7, step=1, dwell=0 → 5,6,7,5,6,7…; abort mid-sequence → dds_ce=0 next cycle, no done, busy=0.
- `load_req`+`start` in the same cycle → LOAD only; `start` during SWEEP ignored; rst mid-LOAD → all outputs at reset values the next cycle.
